// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// loader_pkg : shared types and constants for the boot-time program loader
// Revision   : 1.0
// ============================================================================
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_H  = 3'd1,
        LEN_L  = 3'd2,
        DATA_H = 3'd3,
        DATA_L = 3'd4,
        CHK    = 3'd5,
        RUN    = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam logic [7:0] HDR_DEFAULT    = 8'hA5;
    localparam int         TO_CYC_DEFAULT = 500000;
    localparam int         TO_W           = $clog2(TO_CYC_DEFAULT);

    // Counter width able to hold TO_CYC-1, never narrower than one bit.
    function automatic int cnt_width(input int cyc);
        return (cyc > 2) ? $clog2(cyc) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_byte_timer.sv
`default_nettype none
// ============================================================================
// byte_timer : inter-byte timeout counter, expires after TO_CYC idle cycles
// Revision   : 1.0
// ============================================================================
module byte_timer
    import loader_pkg::*;
#(
    parameter int TO_CYC = TO_CYC_DEFAULT
) (
    input  logic clk50m,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int            TW   = cnt_width(TO_CYC);
    localparam logic [TW-1:0] LAST = TW'(TO_CYC - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    assign expired = run && !clr && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// prog_loader : UART-framed image loader for the instruction ROM, holds CPU
// Revision    : 1.0
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int         DW     = 16,
    parameter int         PW     = 15,
    parameter int         TO_CYC = TO_CYC_DEFAULT,
    parameter logic [7:0] HDR    = HDR_DEFAULT
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rom_we,
    output logic [PW-1:0] rom_addr,
    output logic [DW-1:0] rom_wdata,
    output logic          cpu_hold,
    output logic          loading,
    output logic          done,
    output logic          err
);

    state_t        state;
    logic [15:0]   len;
    logic [7:0]    hi;
    logic [7:0]    chk;
    logic [PW-1:0] idx;
    logic          expired;

    logic [15:0]   len_new;
    logic          too_long;
    logic          last_word;

    assign len_new   = {len[15:8], rx_data};
    assign too_long  = ({1'b0, len_new} > (17'd1 << PW));
    assign last_word = ({{(17-PW){1'b0}}, idx} == ({1'b0, len} - 17'd1));

    byte_timer #(
        .TO_CYC (TO_CYC)
    ) u_timer (
        .clk50m  (clk50m),
        .rst     (rst),
        .clr     (rx_valid),
        .run     (loading),
        .expired (expired)
    );

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            cpu_hold  <= 1'b1;
            loading   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len       <= '0;
            hi        <= '0;
            chk       <= '0;
            idx       <= '0;
        end else begin
            rom_we <= 1'b0;
            if (rx_valid) begin
                case (state)
                    IDLE, RUN, ERR: begin
                        if (rx_data == HDR) begin
                            state    <= LEN_H;
                            cpu_hold <= 1'b1;
                            loading  <= 1'b1;
                            done     <= 1'b0;
                            err      <= 1'b0;
                            chk      <= '0;
                            idx      <= '0;
                        end
                    end
                    LEN_H: begin
                        len[15:8] <= rx_data;
                        chk       <= chk ^ rx_data;
                        state     <= LEN_L;
                    end
                    LEN_L: begin
                        len[7:0] <= rx_data;
                        chk      <= chk ^ rx_data;
                        if (len_new == 16'd0) begin
                            state <= CHK;
                        end else if (too_long) begin
                            state   <= ERR;
                            err     <= 1'b1;
                            loading <= 1'b0;
                        end else begin
                            state <= DATA_H;
                        end
                    end
                    DATA_H: begin
                        hi    <= rx_data;
                        chk   <= chk ^ rx_data;
                        state <= DATA_L;
                    end
                    DATA_L: begin
                        rom_we    <= 1'b1;
                        rom_wdata <= DW'({hi, rx_data});
                        rom_addr  <= idx;
                        idx       <= idx + 1'b1;
                        chk       <= chk ^ rx_data;
                        state     <= last_word ? CHK : DATA_H;
                    end
                    CHK: begin
                        loading <= 1'b0;
                        if (rx_data == chk) begin
                            state    <= RUN;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (expired) begin
                state   <= ERR;
                err     <= 1'b1;
                loading <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_prog_loader : randomized self-checking bench with a frame-position model
// Revision       : 1.0
// ============================================================================
module tb_prog_loader;

    localparam int         PW     = 15;
    localparam int         DW     = 16;
    localparam int         TO_CYC = 1500;
    localparam logic [7:0] HDR    = 8'hA5;

    logic          clk50m = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rom_we;
    logic [PW-1:0] rom_addr;
    logic [DW-1:0] rom_wdata;
    logic          cpu_hold, loading, done, err;

    int n_total = 0;
    int n_pass  = 0;

    prog_loader #(
        .DW     (DW),
        .PW     (PW),
        .TO_CYC (TO_CYC),
        .HDR    (HDR)
    ) dut (
        .clk50m    (clk50m),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_hold  (cpu_hold),
        .loading   (loading),
        .done      (done),
        .err       (err)
    );

    always #5 clk50m = ~clk50m;

    // Model: tracks the byte position inside the frame; data word n sits at
    // positions 3+2n (high) and 4+2n (low), the checksum at 3+2*LEN.
    bit            m_inf  = 0;
    int            m_pos  = 0;
    int            m_len  = 0;
    int            m_idle = 0;
    logic [7:0]    m_hi   = '0;
    logic [7:0]    m_chk  = '0;
    logic          e_we = 0, e_hold = 1, e_loading = 0, e_done = 0, e_err = 0;
    logic [PW-1:0] e_addr  = '0;
    logic [DW-1:0] e_wdata = '0;

    task automatic m_fail();
        m_inf = 0; e_err = 1; e_loading = 0; e_done = 0;
    endtask

    always @(posedge clk50m or posedge rst) begin
        if (rst) begin
            m_inf = 0; m_pos = 0; m_len = 0; m_idle = 0; m_hi = '0; m_chk = '0;
            e_we = 0; e_addr = '0; e_wdata = '0;
            e_hold = 1; e_loading = 0; e_done = 0; e_err = 0;
        end else begin
            e_we = 0;
            if (rx_valid) begin
                m_idle = 0;
                if (!m_inf) begin
                    if (rx_data == HDR) begin
                        m_inf = 1; m_pos = 1; m_chk = '0;
                        e_hold = 1; e_loading = 1; e_done = 0; e_err = 0;
                    end
                end else if (m_pos == 1) begin
                    m_len = int'(rx_data) * 256; m_chk ^= rx_data; m_pos = 2;
                end else if (m_pos == 2) begin
                    m_len += int'(rx_data); m_chk ^= rx_data; m_pos = 3;
                    if (m_len > (1 << PW)) m_fail();
                end else if (m_pos < 3 + 2 * m_len) begin
                    m_chk ^= rx_data;
                    if ((m_pos - 3) % 2 == 0) begin
                        m_hi = rx_data;
                    end else begin
                        e_we    = 1;
                        e_addr  = PW'((m_pos - 3) / 2);
                        e_wdata = {m_hi, rx_data};
                    end
                    m_pos++;
                end else begin
                    m_inf = 0; e_loading = 0;
                    if (rx_data == m_chk) begin
                        e_done = 1; e_hold = 0;
                    end else begin
                        e_err = 1;
                    end
                end
            end else if (m_inf) begin
                m_idle++;
                if (m_idle == TO_CYC) m_fail();
            end
        end
    end

    // Per-cycle comparison and capture of ROM writes.
    logic [35:0]   act_vec, exp_vec;
    int            wr_cnt = 0;
    logic [30:0]   wr_log[$];
    logic [DW-1:0] act_rom[int];

    assign act_vec = {rom_we, rom_addr, rom_wdata, cpu_hold, loading, done, err};
    assign exp_vec = {e_we, e_addr, e_wdata, e_hold, e_loading, e_done, e_err};

    always @(negedge clk50m) begin
        n_total++;
        if (act_vec === exp_vec) n_pass++;
        else $display("FAIL cycle_cmp t=%0t we/addr/wdata/hold/load/done/err act=%h req=%h",
                      $time, act_vec, exp_vec);
        if (rom_we === 1'b1) begin
            wr_cnt++;
            wr_log.push_back({rom_addr, rom_wdata});
            act_rom[int'(rom_addr)] = rom_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h req=%h", name, act, exp);
    endtask

    // Stimulus: every task starts and ends 1 ns after a rising edge.
    logic [7:0]  fb[$];
    logic [15:0] img[10];

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk50m); #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk50m); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_fb(input int gap);
        foreach (fb[i]) begin
            if (i > 0) idle(gap);
            send(fb[i]);
        end
    endtask

    task automatic build_img_frame(input int n);
        logic [7:0] c;
        logic [15:0] l;
        c = '0; l = 16'(n);
        fb.delete();
        fb.push_back(HDR);
        fb.push_back(l[15:8]); c ^= l[15:8];
        fb.push_back(l[7:0]);  c ^= l[7:0];
        for (int i = 0; i < n; i++) begin
            fb.push_back(img[i][15:8]); c ^= img[i][15:8];
            fb.push_back(img[i][7:0]);  c ^= img[i][7:0];
        end
        fb.push_back(c);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        idle(3);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_flags", {29'd0, loading, done, err}, 32'd0);
        check("rst_rom", {rom_we, rom_addr, rom_wdata}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Two-word image back-to-back, checksum 42h.
        fb = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        wr_log.delete(); wr_cnt = 0;
        send_fb(0);
        check("f1_wr_cnt", 32'(wr_cnt), 32'd2);
        if (wr_log.size() == 2) begin
            check("f1_wr0", 32'(wr_log[0]), {1'b0, 15'd0, 16'h1234});
            check("f1_wr1", 32'(wr_log[1]), {1'b0, 15'd1, 16'hABCD});
        end
        check("f1_done_err_hold", {29'd0, done, err, cpu_hold}, 32'b100);
        idle(3);

        // Bad checksum, then the correct frame.
        fb[7] = 8'h43;
        wr_cnt = 0;
        send_fb(0);
        check("badchk_wr_cnt", 32'(wr_cnt), 32'd2);
        check("badchk_done_err_hold", {29'd0, done, err, cpu_hold}, 32'b011);
        idle(2);
        fb[7] = 8'h42;
        send_fb(1);
        check("resend_done_hold", {30'd0, done, cpu_hold}, 32'b10);
        idle(2);

        // Inter-byte timeout.
        fb = '{8'hA5, 8'h00, 8'h01, 8'h12};
        wr_cnt = 0;
        send_fb(0);
        idle(TO_CYC - 1);
        check("to_before", {30'd0, err, loading}, 32'b01);
        idle(1);
        check("to_at", {30'd0, err, loading}, 32'b10);
        check("to_no_we", 32'(wr_cnt), 32'd0);
        idle(5);

        // Empty image recovers from the timeout.
        fb = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_fb(0);
        check("empty_done_hold", {29'd0, done, err, cpu_hold}, 32'b100);
        check("empty_no_we", 32'(wr_cnt), 32'd0);

        // Over-long length 8001h.
        fb = '{8'hA5, 8'h80, 8'h01};
        send_fb(0);
        check("long_err", {29'd0, err, loading, cpu_hold}, 32'b101);
        idle(2);

        // Header from RUN re-holds the CPU; then reset lands in DATA_H.
        fb = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_fb(0);
        send(HDR);
        check("rerun_hold_load", {29'd0, cpu_hold, loading, done}, 32'b110);
        send(8'h00);
        send(8'h02);
        check("pre_rst_addr", 32'(rom_addr), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_rom", {rom_we, rom_addr, rom_wdata}, 32'd0);
        check("midrst_flags", {28'd0, cpu_hold, loading, done, err}, 32'b1000);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Random ten-word images with short and long byte spacing.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) img[i] = 16'($urandom);
            build_img_frame(10);
            wr_cnt = 0;
            send_fb(p == 0 ? 1 : 1000);
            check("rand_wr_cnt", 32'(wr_cnt), 32'd10);
            check("rand_done", {30'd0, done, err}, 32'b10);
            for (int i = 0; i < 10; i++)
                check("rand_rom", 32'(act_rom.exists(i) ? act_rom[i] : 16'hxxxx), 32'(img[i]));
            idle(3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the Hack CPU and its instruction ROM. It receives a framed byte stream from the UART receiver, assembles 16-bit instruction words and writes them into the instruction ROM write port. It holds the CPU in reset until a complete, checksum-verified image is in ROM, then releases it. A new frame header at any later time re-holds the CPU and reloads the ROM.

Parameters:
DW, 16, instruction word width (fixed at 2 bytes; other values are unsupported)
PW, 15, ROM address width (matches the CPU program counter width)
TO_CYC, 500000, inter-byte timeout in clk50m cycles (10 ms at 50 MHz)
HDR, 8'hA5, frame header byte

Ports:
clk50m  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-high
rx_valid  in  1  single-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
rom_we  out  1  ROM write strobe, one cycle per word
rom_addr  out  PW  ROM write address
rom_wdata  out  DW  ROM write data
cpu_hold  out  1  drives the CPU reset (CPU held while 1)
loading  out  1  frame in progress
done  out  1  last frame loaded successfully
err  out  1  last frame failed (checksum, length or timeout)

Behaviour:
- One clock (clk50m); reset is asynchronous and active-high (rst). The block runs every clk50m cycle and is not gated by en25m.
- Reset values: state=IDLE, rom_we=0, rom_addr=0, rom_wdata=0, cpu_hold=1, loading=0, done=0, err=0, all counters 0.
- Frame format: HDR, LEN_H, LEN_L, then LEN words (each sent high byte then low byte), then CHK.
- LEN is an unsigned 16-bit word count. CHK is the XOR of every byte after HDR and before CHK.
- FSM states: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHK, RUN, ERR.
- IDLE / ERR / RUN:
  - rx_valid with rx_data==HDR: go to LEN_H, set cpu_hold=1, loading=1, done=0, err=0, chk=0, word index=0.
  - Any other byte is ignored.
- LEN_H: latch the byte as the length high byte, go to LEN_L.
- LEN_L: latch the length low byte, then:
  - LEN==0: go to CHK.
  - LEN>2**PW: go to ERR.
  - Otherwise: go to DATA_H.
- DATA_H: latch the high byte, go to DATA_L.
- DATA_L: in the cycle after the low byte is accepted:
  - rom_we=1 for exactly one cycle, rom_wdata={hi,lo}, rom_addr=word index.
  - The word index then increments.
  - If this was the last word (index==LEN-1 before increment), go to CHK; else go to DATA_H.
- Every accepted byte from LEN_H through DATA_L is XORed into chk.
- CHK:
  - Byte equals chk: go to RUN, done=1, loading=0, cpu_hold=0 (registered, one cycle after the CHK byte).
  - Mismatch: go to ERR, err=1, loading=0, cpu_hold stays 1.
- ERR: err and cpu_hold stay 1 until the next HDR.
- ROM contents written before a failure are not rolled back.
- Timeout:
  - Counter clears on every rx_valid and counts while loading=1.
  - When it reaches TO_CYC-1 without a byte: go to ERR, err=1.
  - The counter never counts in IDLE, RUN or ERR.
- HDR bytes inside a frame are treated as data; there is no resync mid-frame.
- rx_valid on consecutive cycles must be accepted, so each state consumes at most one byte per cycle.
- rom_addr holds its last value when rom_we=0.
- rst mid-frame returns every output to its reset value immediately; the partial load is abandoned and the CPU stays held.

Decomposition:
- Package loader_pkg:
  - state enum typedef (the eight states above)
  - HDR default constant
  - localparam for the timeout counter width, $clog2(TO_CYC)
- Sub-module byte_timer: the inter-byte timeout counter.
  - Inputs: clk50m, rst, clr, run.
  - Output: expired.
- The FSM, datapath and ROM port stay in prog_loader.

Test Plan:
- Load with HDR,00,02,12,34,AB,CD,42 back-to-back:
  - rom_we pulses twice: addr 0 / 1234, then addr 1 / ABCD.
  - cpu_hold falls one cycle after byte 42; done=1, err=0.
- Same frame with checksum 43 -> both words still written, then err=1, done=0, cpu_hold=1. Resending the correct frame -> done=1, cpu_hold=0.
- Send HDR,00,01,12, then idle for TO_CYC cycles -> err=1 exactly at the timeout, no rom_we. A later HDR restarts cleanly.
- Send HDR,00,00,00 -> no rom_we, done=1, cpu_hold=0. Send HDR,80,01 -> err=1 immediately after 01 (8001h > 2**15).
- From RUN, send HDR -> cpu_hold=1 on the next cycle and loading=1. Assert rst during DATA_H -> all outputs at reset values, rom_addr=0.
- Bytes spaced 1 cycle and 1000 cycles apart with random 10-word images -> ROM model matches the image; rom_we count equals 10.
